// File: rtl/striping_n.sv
// Round-robin striper: spreads one word stream across LANES output lanes in strict
// rotating order, with per-lane valid/ready holding registers and a saturating word counter.
module striping_n #(
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned LANES        = 2,
  parameter int unsigned ADVANCE_MODE = 0,
  parameter int unsigned CNT_WIDTH    = 16
) (
  input  logic                          clk_2f,
  input  logic                          reset,
  input  logic [DATA_WIDTH-1:0]         data_in,
  input  logic                          valid_in,
  output logic                          ready_in,
  output logic [LANES*DATA_WIDTH-1:0]   lane_data,
  output logic [LANES-1:0]              lane_valid,
  input  logic [LANES-1:0]              lane_ready,
  output logic [$clog2(LANES)-1:0]      sel,
  output logic [CNT_WIDTH-1:0]          word_count
);

  localparam int unsigned SEL_W = $clog2(LANES);

  logic accept;
  logic stall;
  logic advance;

  // Selected lane can take a word if it is empty or draining this edge
  always_comb begin
    ready_in = !lane_valid[sel] || lane_ready[sel];
    accept   = valid_in && ready_in;
    stall    = valid_in && !ready_in;
    advance  = (ADVANCE_MODE != 0) ? accept : !stall;
  end

  // Lane pointer; LANES is a power of two so the increment wraps naturally
  always_ff @(posedge clk_2f) begin
    if (reset) begin
      sel <= '0;
    end else if (advance) begin
      sel <= sel + SEL_W'(1);
    end
  end

  // Saturating count of accepted words
  always_ff @(posedge clk_2f) begin
    if (reset) begin
      word_count <= '0;
    end else if (accept && (word_count != {CNT_WIDTH{1'b1}})) begin
      word_count <= word_count + CNT_WIDTH'(1);
    end
  end

  // Per-lane holding registers; a refill on the draining edge keeps valid high
  always_ff @(posedge clk_2f) begin
    if (reset) begin
      lane_data  <= '0;
      lane_valid <= '0;
    end else begin
      for (int unsigned i = 0; i < LANES; i++) begin
        if (accept && (sel == SEL_W'(i))) begin
          lane_data[i*DATA_WIDTH +: DATA_WIDTH] <= data_in;
          lane_valid[i]                         <= 1'b1;
        end else if (lane_valid[i] && lane_ready[i]) begin
          lane_valid[i] <= 1'b0;
        end
      end
    end
  end

endmodule

// File: doc/striping_n.md
# striping_n

Parametrised round-robin striper with per-lane valid/ready handshakes. It distributes a single stream of `DATA_WIDTH`-bit words across `LANES` output lanes in strict rotating order. It sits between the clk_2f-domain source and the per-lane serialisers, and is the generalised replacement for the fixed two-lane striper. It adds lane backpressure, a selectable pointer-advance mode and an accepted-word counter.

## Interface
- `DATA_WIDTH`, 32, width of each word and each lane.
- `LANES`, 2, number of output lanes; power of two, 2..8.
- `ADVANCE_MODE`, 0, 0 = pointer rotates every cycle (idle slots consumed); 1 = pointer advances only on an accepted word.
- `CNT_WIDTH`, 16, width of the accepted-word counter.

Ports:
- `clk_2f`  in  1  clock; all logic on rising edge.
- `reset`  in  1  synchronous, active-high.
- `data_in`  in  DATA_WIDTH  input word.
- `valid_in`  in  1  `data_in` valid.
- `ready_in`  out  1  block can accept into the lane currently selected; combinational.
- `lane_data`  out  LANES*DATA_WIDTH  lane i occupies bits [i*DATA_WIDTH +: DATA_WIDTH]; registered.
- `lane_valid`  out  LANES  per-lane valid; registered.
- `lane_ready`  in  LANES  per-lane downstream ready.
- `sel`  out  $clog2(LANES)  current lane pointer; registered.
- `word_count`  out  CNT_WIDTH  words accepted since reset; saturating.

## Operation
- Each lane has one holding register with data and valid bits. A lane is **full** when `lane_valid[i]` = 1.
- `ready_in` = !lane_valid[sel] || lane_ready[sel].
- **Accept** = valid_in && ready_in. On accept:
  - data_in is written to lane `sel`.
  - lane_valid[sel] is set to 1.
  - word_count increments by 1 and saturates at 2^CNT_WIDTH-1.
- **Drain**: lane i clears lane_valid[i] at an edge where lane_valid[i] && lane_ready[i] and lane i is not written on that edge.
- **Drain and refill on the same edge** of the same lane: valid stays 1 and the data takes the new word.
- lane_data[i] holds its last written value while not valid. It never outputs X or Z.
- Pointer, ADVANCE_MODE=0:
  - sel advances (sel+1 mod LANES) on every edge, except when valid_in=1 and ready_in=0 (stall).
  - While stalled, sel holds and no lane is written.
  - A cycle with valid_in=0 consumes that lane slot. No data is written and the lane keeps its state.
- Pointer, ADVANCE_MODE=1: sel advances only on accept. Otherwise it holds.
- Wrap-around: sel goes LANES-1 -> 0. No other reordering ever occurs.
- Lanes other than `sel` drain independently of the input side.

## Timing
- Reset values: sel=0, lane_valid=0, lane_data=0, word_count=0.
- ready_in is combinational and has no meaning during reset. Nothing is accepted while reset=1.
- Reset mid-operation: all held lane words are discarded at the reset edge. The first word after reset goes to lane 0.
- Latency: a word accepted at edge k is visible on lane_data/lane_valid after edge k, i.e. one cycle.
- sel and word_count update on the same edge as the accept.
- No combinational path from data_in to any output. The only combinational path is lane_ready[sel]/sel -> ready_in.
- Sustained throughput is 1 word per clk_2f cycle when all lanes drain every cycle.

## Test plan
- **Basic rotation.** LANES=4, MODE=1, lane_ready all 1, valid_in=1 with words 0xA0..0xA7.
  - Required: lane0 gets A0 then A4, lane1 gets A1 then A5, and so on.
  - Required: each lane_valid pulses 1 cycle after its word; word_count=8.
- **Idle slot, MODE=0.** LANES=2, sequence valid_in 1,0,1 with D0, –, D2.
  - Required: D0 goes to lane0 and D2 goes to lane0.
  - Required: lane1 is never written and lane_valid[1] stays 0; sel toggles every cycle.
- **Idle slot, MODE=1.** Same stimulus.
  - Required: D0 goes to lane0 and D2 goes to lane1; sel holds during the idle cycle.
- **Backpressure.** LANES=2, lane_ready[1]=0 with lane1 full, valid_in=1 with sel=1.
  - Required: ready_in=0, sel holds, lane1 data unchanged.
  - Raise lane_ready[1] -> required: accept on the next edge and the new word replaces the old one, with valid staying 1.
- **Reset mid-stream.** Assert reset with lanes full and sel=1.
  - Required: after the edge, all lane_valid=0, lane_data=0, sel=0, word_count=0.
  - Required: the next accepted word goes to lane0.
- **Counter saturation.** CNT_WIDTH=4, accept 20 words.
  - Required: word_count reaches 15 and holds, while striping continues correctly.
